// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate divider, horizontal/vertical scan
// counters and registered sync, blanking and coordinate outputs.
module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       pixel_tick,
  output logic       frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

  // True when val lies in [lo, lo+len-1].
  function automatic logic in_window(input logic [9:0] val, input int lo, input int len);
    return (int'(val) >= lo) && (int'(val) < lo + len);
  endfunction

  logic [DIV_W-1:0] div_cnt;
  logic             adv_p0;
  logic [9:0]       h_p0, v_p0;
  logic             hsync_p0, vsync_p0, video_p0;
  logic [9:0]       h_p1, v_p1;
  logic             hsync_p1, vsync_p1, video_p1;
  logic             tick_p1, frame_p1;

  // Stage p0: pixel-advance strobe, next scan position and its decode.
  always_comb begin
    adv_p0 = enable && (div_cnt == DIV_LAST);
    h_p0   = h_p1 + 10'd1;
    v_p0   = v_p1;
    if (h_p1 == H_LAST) begin
      h_p0 = '0;
      v_p0 = (v_p1 == V_LAST) ? '0 : v_p1 + 10'd1;
    end
    hsync_p0 = !in_window(h_p0, H_DISPLAY + H_FRONT, H_SYNC);
    vsync_p0 = !in_window(v_p0, V_DISPLAY + V_FRONT, V_SYNC);
    video_p0 = in_window(h_p0, 0, H_DISPLAY) && in_window(v_p0, 0, V_DISPLAY);
  end

  // Clock divider: counts system clocks within the current pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (enable) begin
      div_cnt <= adv_p0 ? '0 : div_cnt + 1'b1;
    end
  end

  // Stage p1: scan position and level outputs, loaded together on each advance.
  // Reset parks on the last pixel of a frame so the first advance lands on (0,0).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_p1     <= H_LAST;
      v_p1     <= V_LAST;
      hsync_p1 <= 1'b1;
      vsync_p1 <= 1'b1;
      video_p1 <= 1'b0;
    end else if (adv_p0) begin
      h_p1     <= h_p0;
      v_p1     <= v_p0;
      hsync_p1 <= hsync_p0;
      vsync_p1 <= vsync_p0;
      video_p1 <= video_p0;
    end
  end

  // Stage p1: one-clock strobes marking a fresh pixel and the start of a frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_p1  <= 1'b0;
      frame_p1 <= 1'b0;
    end else begin
      tick_p1  <= adv_p0;
      frame_p1 <= adv_p0 && (h_p0 == '0) && (v_p0 == '0);
    end
  end

  assign pix_x    = h_p1;
  assign pix_y    = v_p1;
  assign hsync    = hsync_p1;
  assign vsync    = vsync_p1;
  assign video_on = video_p1;
  // Strobes are masked by enable so a paused generator never reports a new pixel.
  assign pixel_tick  = tick_p1 & enable;
  assign frame_start = frame_p1 & enable;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default-timing, reduced-timing and CLK_DIV=1 instances
// checked against a behavioural scan model through an expected-value queue.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [2:0] en;

  logic [9:0] px0, py0, px1, py1, px2, py2;
  logic hs0, vs0, vo0, pt0, fs0;
  logic hs1, vs1, vo1, pt1, fs1;
  logic hs2, vs2, vo2, pt2, fs2;

  int n_checks = 0;
  int n_fail   = 0;

  // DUT 0: default 640x480 timing, CLK_DIV=4
  vga_sync_gen u_def (
    .clk(clk), .reset_n(reset_n), .enable(en[0]),
    .pix_x(px0), .pix_y(py0), .hsync(hs0), .vsync(vs0), .video_on(vo0),
    .pixel_tick(pt0), .frame_start(fs0));

  // DUT 1: reduced timing (17x12), CLK_DIV=3
  vga_sync_gen #(.CLK_DIV(3), .H_DISPLAY(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                 .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(3)) u_small (
    .clk(clk), .reset_n(reset_n), .enable(en[1]),
    .pix_x(px1), .pix_y(py1), .hsync(hs1), .vsync(vs1), .video_on(vo1),
    .pixel_tick(pt1), .frame_start(fs1));

  // DUT 2: reduced timing (17x12), CLK_DIV=1
  vga_sync_gen #(.CLK_DIV(1), .H_DISPLAY(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                 .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(3)) u_div1 (
    .clk(clk), .reset_n(reset_n), .enable(en[2]),
    .pix_x(px2), .pix_y(py2), .hsync(hs2), .vsync(vs2), .video_on(vo2),
    .pixel_tick(pt2), .frame_start(fs2));

  // Per-instance timing parameters
  function automatic int p_cd(input int d);
    case (d) 0: return 4; 1: return 3; default: return 1; endcase
  endfunction
  function automatic int p_hd(input int d); return (d == 0) ? 640 : 10; endfunction
  function automatic int p_hf(input int d); return (d == 0) ? 16  : 2;  endfunction
  function automatic int p_hs(input int d); return (d == 0) ? 96  : 3;  endfunction
  function automatic int p_hb(input int d); return (d == 0) ? 48  : 2;  endfunction
  function automatic int p_vd(input int d); return (d == 0) ? 480 : 6;  endfunction
  function automatic int p_vf(input int d); return (d == 0) ? 10  : 1;  endfunction
  function automatic int p_vs(input int d); return 2; endfunction
  function automatic int p_vb(input int d); return (d == 0) ? 33  : 3;  endfunction
  function automatic int p_ht(input int d); return p_hd(d) + p_hf(d) + p_hs(d) + p_hb(d); endfunction
  function automatic int p_vt(input int d); return p_vd(d) + p_vf(d) + p_vs(d) + p_vb(d); endfunction

  function automatic logic [24:0] dut_vec(input int d);
    case (d)
      0:       return {px0, py0, hs0, vs0, vo0, pt0, fs0};
      1:       return {px1, py1, hs1, vs1, vo1, pt1, fs1};
      default: return {px2, py2, hs2, vs2, vo2, pt2, fs2};
    endcase
  endfunction

  // Behavioural scan model
  int   md[3], mh[3], mv[3];
  logic mpt[3], mfs[3];

  typedef struct { int d; logic [24:0] v; } exp_t;
  exp_t exp_q[$];

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      md[d] = 0; mh[d] = p_ht(d) - 1; mv[d] = p_vt(d) - 1; mpt[d] = 1'b0; mfs[d] = 1'b0;
    end
  endtask

  function automatic void model_step(input int d, input logic e);
    mpt[d] = 1'b0;
    mfs[d] = 1'b0;
    if (e) begin
      if (md[d] == p_cd(d) - 1) begin
        md[d] = 0;
        if (mh[d] == p_ht(d) - 1) begin
          mh[d] = 0;
          mv[d] = (mv[d] == p_vt(d) - 1) ? 0 : mv[d] + 1;
        end else begin
          mh[d] = mh[d] + 1;
        end
        mpt[d] = 1'b1;
        mfs[d] = (mh[d] == 0) && (mv[d] == 0);
      end else begin
        md[d] = md[d] + 1;
      end
    end
  endfunction

  function automatic logic [24:0] model_vec(input int d);
    int   hlo, vlo;
    logic hsv, vsv, vov;
    hlo = p_hd(d) + p_hf(d);
    vlo = p_vd(d) + p_vf(d);
    hsv = !(mh[d] >= hlo && mh[d] < hlo + p_hs(d));
    vsv = !(mv[d] >= vlo && mv[d] < vlo + p_vs(d));
    vov = (mh[d] < p_hd(d)) && (mv[d] < p_vd(d));
    return {10'(mh[d]), 10'(mv[d]), hsv, vsv, vov, mpt[d], mfs[d]};
  endfunction

  // Drive n clock cycles; expected outputs for each cycle are queued before its edge.
  task automatic tick(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      for (int d = 0; d < 3; d++) begin
        model_step(d, en[d]);
        e.d = d;
        e.v = model_vec(d);
        exp_q.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
      #1;
    end
  endtask

  // Scoreboard: pop the expectations for the last edge and compare every instance.
  exp_t        mon_e;
  logic [24:0] mon_a;
  always @(negedge clk) begin
    if (exp_q.size() >= 3) begin
      for (int k = 0; k < 3; k++) begin
        mon_e = exp_q.pop_front();
        mon_a = dut_vec(mon_e.d);
        n_checks++;
        if (mon_a !== mon_e.v) begin
          n_fail++;
          $display("FAIL scoreboard dut%0d @%0t: got x=%0d y=%0d hs,vs,vo,pt,fs=%b expected x=%0d y=%0d hs,vs,vo,pt,fs=%b",
                   mon_e.d, $time, mon_a[24:15], mon_a[14:5], mon_a[4:0],
                   mon_e.v[24:15], mon_e.v[14:5], mon_e.v[4:0]);
        end
      end
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    en      = 3'b000;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (px0 !== 10'd799) begin n_fail++; $display("FAIL reset_pix_x: got %0d expected 799", px0); end
    n_checks++;
    if (py0 !== 10'd524) begin n_fail++; $display("FAIL reset_pix_y: got %0d expected 524", py0); end
    n_checks++;
    if ({hs0, vs0} !== 2'b11) begin n_fail++; $display("FAIL reset_sync: got hs,vs=%b expected 11", {hs0, vs0}); end
    n_checks++;
    if ({vo0, pt0, fs0} !== 3'b000) begin n_fail++; $display("FAIL reset_vo_pulses: got %b expected 000", {vo0, pt0, fs0}); end
    n_checks++;
    if ({px1, py1, px2, py2} !== {10'd16, 10'd11, 10'd16, 10'd11}) begin
      n_fail++; $display("FAIL reset_small: got (%0d,%0d) (%0d,%0d) expected (16,11) (16,11)", px1, py1, px2, py2);
    end
    reset_n = 1'b1;
    en      = 3'b111;
    model_reset();
  endtask

  task automatic test_first_advance();
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      n_checks++;
      if (i == 4) begin
        if ({px0, py0, vo0, pt0, fs0} !== {10'd0, 10'd0, 3'b111}) begin
          n_fail++; $display("FAIL first_advance edge4: got x=%0d y=%0d vo,pt,fs=%b expected x=0 y=0 vo,pt,fs=111",
                             px0, py0, {vo0, pt0, fs0});
        end
      end else if (i == 8) begin
        if ({px0, pt0, fs0} !== {10'd1, 2'b10}) begin
          n_fail++; $display("FAIL second_advance edge8: got x=%0d pt,fs=%b expected x=1 pt,fs=10", px0, {pt0, fs0});
        end
      end else if (i < 4) begin
        if ({px0, pt0} !== {10'd799, 1'b0}) begin
          n_fail++; $display("FAIL pre_advance edge%0d: got x=%0d pt=%b expected x=799 pt=0", i, px0, pt0);
        end
      end else begin
        if ({px0, pt0, fs0} !== {10'd0, 2'b00}) begin
          n_fail++; $display("FAIL pulse_width edge%0d: got x=%0d pt,fs=%b expected x=0 pt,fs=00", i, px0, {pt0, fs0});
        end
      end
    end
  endtask

  task automatic test_hsync_line();
    logic [9:0] xp, yp;
    logic       hsp, vop;
    bit         wrapped;
    int         seen;
    xp = px0; yp = py0; hsp = hs0; vop = vo0; wrapped = 0; seen = 0;
    for (int i = 0; i < 3400 && !wrapped; i++) begin
      tick(1);
      if (pt0) begin
        if (px0 == 10'd656) begin
          seen++; n_checks++;
          if ({xp, hsp, hs0} !== {10'd655, 2'b10}) begin
            n_fail++; $display("FAIL hsync_fall: got prev x=%0d hs %b->%b expected 655 hs 1->0", xp, hsp, hs0);
          end
        end
        if (px0 == 10'd752) begin
          seen++; n_checks++;
          if ({xp, hsp, hs0} !== {10'd751, 2'b01}) begin
            n_fail++; $display("FAIL hsync_rise: got prev x=%0d hs %b->%b expected 751 hs 0->1", xp, hsp, hs0);
          end
        end
        if (px0 == 10'd640) begin
          seen++; n_checks++;
          if ({vop, vo0} !== 2'b10) begin
            n_fail++; $display("FAIL video_off: got vo %b->%b expected 1->0", vop, vo0);
          end
        end
        if (px0 == 10'd0) begin
          wrapped = 1; n_checks++;
          if ({xp, py0} !== {10'd799, yp + 10'd1}) begin
            n_fail++; $display("FAIL line_wrap: got prev x=%0d y=%0d expected prev x=799 y=%0d", xp, py0, yp + 10'd1);
          end
        end
        xp = px0; yp = py0; hsp = hs0; vop = vo0;
      end
    end
    n_checks++;
    if (!wrapped || seen != 3) begin
      n_fail++; $display("FAIL hsync_line_coverage: got wrapped=%0d events=%0d expected 1 and 3", wrapped, seen);
    end
  endtask

  task automatic test_vsync_frame();
    int         t, t1, t2, vs_lines;
    logic [9:0] xp, yp;
    t = 0; t1 = -1; t2 = -1; vs_lines = 0; xp = px1; yp = py1;
    while (t2 < 0 && t < 2000) begin
      tick(1);
      t++;
      if (pt1) begin
        n_checks++;
        if (vs1 !== !(py1 == 10'd7 || py1 == 10'd8)) begin
          n_fail++; $display("FAIL vsync_window: got vs=%b at y=%0d expected low only for y 7..8", vs1, py1);
        end
        if (t1 >= 0 && px1 == 10'd0 && !vs1) vs_lines++;
        if (fs1) begin
          n_checks++;
          if ({xp, yp, px1, py1} !== {10'd16, 10'd11, 10'd0, 10'd0}) begin
            n_fail++; $display("FAIL frame_wrap: got (%0d,%0d)->(%0d,%0d) expected (16,11)->(0,0)", xp, yp, px1, py1);
          end
          if (t1 < 0) t1 = t; else t2 = t;
        end
        xp = px1; yp = py1;
      end
    end
    n_checks++;
    if (t2 < 0 || t2 - t1 != 612) begin
      n_fail++; $display("FAIL frame_period: got %0d clks expected 612", (t2 < 0) ? -1 : t2 - t1);
    end
    n_checks++;
    if (vs_lines != 2) begin
      n_fail++; $display("FAIL vsync_lines: got %0d expected 2", vs_lines);
    end
  endtask

  task automatic test_enable_hold();
    logic [24:0] held;
    logic [9:0]  hx;
    int          cnt;
    bit          found;
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick(1);
      if (pt0) found = 1;
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL enable_sync: got no pixel_tick expected one within 8 clks"); end
    tick(2);
    held = {px0, py0, hs0, vs0, vo0, 2'b00};
    hx   = px0;
    en[0] = 1'b0;
    for (int i = 0; i < 37; i++) begin
      tick(1);
      n_checks++;
      if ({px0, py0, hs0, vs0, vo0, pt0, fs0} !== held) begin
        n_fail++; $display("FAIL enable_hold cycle%0d: got x=%0d pt=%b expected x=%0d pt=0", i, px0, pt0, hx);
      end
    end
    en[0] = 1'b1;
    cnt = 0; found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick(1);
      cnt++;
      if (pt0) found = 1;
    end
    n_checks++;
    if (!found || cnt != 2) begin
      n_fail++; $display("FAIL enable_resume_phase: got %0d clks to next tick expected 2", found ? cnt : -1);
    end
    n_checks++;
    if (px0 !== ((hx == 10'd799) ? 10'd0 : hx + 10'd1)) begin
      n_fail++; $display("FAIL enable_resume_pixel: got x=%0d expected successor of %0d", px0, hx);
    end
  endtask

  task automatic test_div1();
    logic [9:0] xp;
    int         t, t1;
    bit         found;
    xp = px2;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      n_checks++;
      if ({pt2, px2} !== {1'b1, (xp == 10'd16) ? 10'd0 : xp + 10'd1}) begin
        n_fail++; $display("FAIL div1_step: got pt=%b x=%0d expected pt=1 successor of %0d", pt2, px2, xp);
      end
      xp = px2;
    end
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick(1);
      if (fs2) found = 1;
    end
    t1 = -1;
    t  = 0;
    while (found && t1 < 0 && t < 300) begin
      tick(1);
      t++;
      if (fs2) t1 = t;
    end
    n_checks++;
    if (t1 != 204) begin
      n_fail++; $display("FAIL div1_frame_period: got %0d clks expected 204", t1);
    end
  endtask

  task automatic test_async_reset();
    tick(5);
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({px0, py0, hs0, vs0, vo0, pt0, fs0} !== {10'd799, 10'd524, 5'b11000}) begin
      n_fail++; $display("FAIL async_reset_immediate: got x=%0d y=%0d hs,vs,vo,pt,fs=%b expected 799 524 11000",
                         px0, py0, {hs0, vs0, vo0, pt0, fs0});
    end
    n_checks++;
    if ({px1, py1, px2, py2} !== {10'd16, 10'd11, 10'd16, 10'd11}) begin
      n_fail++; $display("FAIL async_reset_small: got (%0d,%0d) (%0d,%0d) expected (16,11) (16,11)", px1, py1, px2, py2);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if ({px0, py0, pt0} !== {10'd799, 10'd524, 1'b0}) begin
      n_fail++; $display("FAIL async_reset_hold: got x=%0d y=%0d pt=%b expected 799 524 0", px0, py0, pt0);
    end
    reset_n = 1'b1;
    model_reset();
    tick(4);
    n_checks++;
    if ({px0, py0, fs0} !== {10'd0, 10'd0, 1'b1}) begin
      n_fail++; $display("FAIL post_reset_advance: got x=%0d y=%0d fs=%b expected 0 0 1", px0, py0, fs0);
    end
    tick(3);
  endtask

  initial begin
    test_reset();
    test_first_advance();
    test_hsync_line();
    test_vsync_frame();
    test_enable_hold();
    test_div1();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation time limit expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Free-running VGA 640x480@60 timing generator. Divides the system clock into a pixel-rate enable, scans horizontal and vertical counters, and drives registered `hsync`, `vsync`, `video_on` and the `pix_x`/`pix_y` coordinates. It is the producer of the pixel-coordinate stream consumed by the text/initials generator (`Iniciales`) and the RGB output stage. All its outputs go directly to the monitor connector or feed downstream pixel logic.

## Interface

**Parameters**
- `CLK_DIV`, 4: system clocks per pixel (≥1). 100 MHz → 25 MHz pixel rate.
- `H_DISPLAY`, 640: visible pixels per line.
- `H_FRONT`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: hsync pulse width, in pixels.
- `H_BACK`, 48: horizontal back porch. H_TOTAL = 800.
- `V_DISPLAY`, 480: visible lines.
- `V_FRONT`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vsync pulse width, in lines.
- `V_BACK`, 33: vertical back porch. V_TOTAL = 525.

**Ports** (name, direction, width, meaning)
- `clk`, in, 1: system clock. The block uses only this clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: synchronous run enable. When low, the divider and counters hold.
- `pix_x`, out, 10: current horizontal count, 0..H_TOTAL-1.
- `pix_y`, out, 10: current vertical count, 0..V_TOTAL-1.
- `hsync`, out, 1: horizontal sync, active low.
- `vsync`, out, 1: vertical sync, active low.
- `video_on`, out, 1: high while (`pix_x`,`pix_y`) is inside the visible area.
- `pixel_tick`, out, 1: one-clk pulse in the first cycle a new pixel's outputs are valid.
- `frame_start`, out, 1: one-clk pulse coincident with `pixel_tick` when the coordinates become (0,0).

## Operation

**Divider**
- `div_cnt` counts 0..CLK_DIV-1 while `enable` is high and wraps to 0.
- A pixel advance occurs on the clk edge where `div_cnt == CLK_DIV-1`.
- With CLK_DIV = 1, a pixel advance occurs on every enabled edge.

**Counters** (updated only on a pixel advance)
- h = H_TOTAL-1 → h = 0 and v increments. Otherwise h increments.
- h and v both at their maximum (H_TOTAL-1, V_TOTAL-1) → both go to 0.

**Outputs** (all registered, all updated on the same edge as the counters, so they are mutually aligned)
- `pix_x` = h, `pix_y` = v.
- `hsync` = 0 iff H_DISPLAY+H_FRONT ≤ h ≤ H_DISPLAY+H_FRONT+H_SYNC-1 (656..751).
- `vsync` = 0 iff V_DISPLAY+V_FRONT ≤ v ≤ V_DISPLAY+V_FRONT+V_SYNC-1 (490..491).
- `video_on` = (h < H_DISPLAY) && (v < V_DISPLAY).
- `pixel_tick` = 1 for exactly the one clk following each pixel advance, otherwise 0.
- `frame_start` = 1 for the one clk following the advance into (0,0), otherwise 0.

**Enable**
- `enable` low freezes `div_cnt`, h, v and all level outputs.
- `pixel_tick` and `frame_start` read 0 while `enable` is low.
- Raising `enable` resumes counting from the held `div_cnt`.

**Reset**
- While `reset_n` = 0: `div_cnt` = 0, h = 799, v = 524.
- Output values during reset: `pix_x` = 799, `pix_y` = 524, `hsync` = 1, `vsync` = 1, `video_on` = 0, `pixel_tick` = 0, `frame_start` = 0.
- These values are the last pixel of a frame, so the first advance after reset lands on (0,0) with `frame_start`.
- Reset asserted mid-frame forces these values immediately, with no wait for a clk edge.

## Timing

- Steady state: one pixel advance every CLK_DIV clks.
- One line = 800·CLK_DIV clks. One frame = 420,000·CLK_DIV clks (1,680,000 at the default).
- Latency from counter state to outputs is zero extra cycles. Sync and `video_on` are decoded from next-state values, so they change on the same edge as `pix_x`/`pix_y`.
- First advance after `reset_n` deassertion (with `enable` = 1) occurs on the CLK_DIV-th rising edge. `pixel_tick`, `frame_start`, `video_on` = 1 and (0,0) are visible after that edge.
- `reset_n` deassertion is synchronized externally. The block does not re-synchronize it.

## Test plan

1. **Reset values.** Hold `reset_n` = 0 for 5 clks → `pix_x` = 799, `pix_y` = 524, `hsync` = `vsync` = 1, `video_on` = 0, both pulses 0. Assert reset asynchronously between edges → outputs change immediately.
2. **First advance.** CLK_DIV = 4, release reset with `enable` = 1 → after edge 4: (0,0), `video_on` = 1, `frame_start` = 1 and `pixel_tick` = 1 for exactly 1 clk. Next advance at edge 8.
3. **hsync window and line wrap.**
   - `hsync` falls when `pix_x` goes 655 → 656 and rises on 751 → 752.
   - `video_on` falls on 639 → 640.
   - 799 → 0 increments `pix_y` by 1.
4. **vsync window and frame wrap.**
   - `vsync` is low only for `pix_y` 490–491.
   - (799,524) → (0,0) asserts `frame_start`.
   - Frame period measured at 1,680,000 clks.
5. **Enable hold.** Drop `enable` for 37 clks mid-line → all outputs hold and `pixel_tick` stays 0. Resuming continues from the same `div_cnt` phase with no skipped or repeated pixel.
6. **CLK_DIV = 1 instance.** `pixel_tick` is constantly 1 after reset. `pix_x` increments every clk. Frame period is 420,000 clks.
